// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: bus widths, arbiter state encoding and the
// packed request bundle that the arbiter muxes onto the shared slave port.
// Pure declarations; no logic, no latency, no flow control.
package lc3b_types;

    typedef logic [127:0] lc3b_datbus;
    typedef logic [15:0]  lc3b_mem_wmask;
    typedef logic [11:0]  lc3b_line_adr;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 64;

    // One requester's complete request, muxed as a unit onto the slave side.
    typedef struct packed {
        lc3b_line_adr  adr;
        lc3b_datbus    dat;
        lc3b_mem_wmask sel;
        logic          stb;
        logic          cyc;
        logic          we;
    } arb_req_t;

    // Counter width able to hold 0..cycles-1, never narrower than one bit.
    function automatic int unsigned arb_cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts grant cycles without slave ack, flags expiry at TIMEOUT_CYCLES-1.
// Latency: expiry flag is combinational from the registered count (same cycle).
// Backpressure: none; counter clears whenever no grant is active.
// Ports: clk, rst_n (async active-low), active (a grant is held), ack (slave ack
// this cycle), expired (grant has run out of time this cycle).
module arb_watchdog
    import lc3b_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int unsigned   CW   = arb_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count sits at zero outside a grant, so every grant starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active) begin
            count <= '0;
        end else if (!ack) begin
            count <= count + CW'(1);
        end
    end

    // An ack arriving on the last cycle completes normally rather than retrying.
    assign expired = active && (count == LAST) && !ack;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter onto one shared memory slave (Wishbone-style).
// Latency: one arbitration cycle in IDLE, then request passes combinationally; one idle bubble after each transfer.
// Backpressure: requester waits for ack/rty; losing requester simply keeps its strobe high until granted.
// Ports: m0_*/m1_* requester request (adr, dat_m, sel, stb, cyc, we) and
// response (ack, rty, dat_s); s_* shared slave request and response.
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to force-release a grant
// with a retry after TIMEOUT_CYCLES cycles without ack.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,

    input  lc3b_line_adr  m0_adr,
    input  lc3b_datbus    m0_dat_m,
    input  lc3b_mem_wmask m0_sel,
    input  logic          m0_stb,
    input  logic          m0_cyc,
    input  logic          m0_we,
    output logic          m0_ack,
    output logic          m0_rty,
    output lc3b_datbus    m0_dat_s,

    input  lc3b_line_adr  m1_adr,
    input  lc3b_datbus    m1_dat_m,
    input  lc3b_mem_wmask m1_sel,
    input  logic          m1_stb,
    input  logic          m1_cyc,
    input  logic          m1_we,
    output logic          m1_ack,
    output logic          m1_rty,
    output lc3b_datbus    m1_dat_s,

    output lc3b_line_adr  s_adr,
    output lc3b_datbus    s_dat_m,
    output lc3b_mem_wmask s_sel,
    output logic          s_stb,
    output logic          s_cyc,
    output logic          s_we,
    input  logic          s_ack,
    input  logic          s_rty,
    input  lc3b_datbus    s_dat_s
);

    arb_state_t state;
    logic       last_gnt;     // requester served most recently (1 = m1)

    arb_req_t   req0;
    arb_req_t   req1;
    arb_req_t   gnt_req;
    logic       granted;
    logic       gnt_sel;
    logic       expire;
    logic       release_gnt;

    assign req0 = '{adr: m0_adr, dat: m0_dat_m, sel: m0_sel,
                    stb: m0_stb, cyc: m0_cyc, we: m0_we};
    assign req1 = '{adr: m1_adr, dat: m1_dat_m, sel: m1_sel,
                    stb: m1_stb, cyc: m1_cyc, we: m1_we};

    assign granted = (state == GNT0) || (state == GNT1);
    assign gnt_sel = (state == GNT1);

    // Only the granted requester reaches the slave; IDLE drives all zeros.
    always_comb begin
        gnt_req = '0;
        case (state)
            GNT0:    gnt_req = req0;
            GNT1:    gnt_req = req1;
            default: gnt_req = '0;
        endcase
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (granted),
        .ack     (s_ack),
        .expired (expire)
    );
`else
    // Without the watchdog a grant is held until ack, rty or abort.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign expire         = 1'b0;
`endif

    // Slave request side. On expiry the strobe is withdrawn so the slave
    // does not see a request that is about to be abandoned.
    assign s_adr   = gnt_req.adr;
    assign s_dat_m = gnt_req.dat;
    assign s_sel   = gnt_req.sel;
    assign s_stb   = gnt_req.stb & ~expire;
    assign s_cyc   = gnt_req.cyc;
    assign s_we    = gnt_req.we;

    // Response side: read data broadcast, handshake only to the owner.
    assign m0_dat_s = s_dat_s;
    assign m1_dat_s = s_dat_s;
    assign m0_ack   = (state == GNT0) & s_ack;
    assign m1_ack   = (state == GNT1) & s_ack;
    assign m0_rty   = (state == GNT0) & (s_rty | expire);
    assign m1_rty   = (state == GNT1) & (s_rty | expire);

    // A completed (ack), retried or timed-out grant counts as service.
    assign release_gnt = granted & (s_ack | s_rty | expire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_stb && m1_stb) begin
                        // Tie goes to whoever was not served last.
                        state <= last_gnt ? GNT0 : GNT1;
                    end else if (m0_stb) begin
                        state <= GNT0;
                    end else if (m1_stb) begin
                        state <= GNT1;
                    end
                end
                GNT0, GNT1: begin
                    if (release_gnt) begin
                        // Completion wins over a simultaneous abort.
                        state    <= IDLE;
                        last_gnt <= gnt_sel;
                    end else if (!gnt_req.stb) begin
                        // Requester abort: not counted as service.
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int TO = 8;
`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [11:0]  m_adr [2];
    logic [127:0] m_dat [2];
    logic [15:0]  m_sel [2];
    logic         m_stb [2];
    logic         m_cyc [2];
    logic         m_we  [2];
    logic         m0_ack, m0_rty, m1_ack, m1_rty;
    logic [127:0] m0_dat_s, m1_dat_s;
    logic [11:0]  s_adr;
    logic [127:0] s_dat_m;
    logic [15:0]  s_sel;
    logic         s_stb, s_cyc, s_we;
    logic         s_ack, s_rty;
    logic [127:0] s_dat_s;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: owner (-1 none), last served, cycles into grant.
    int own;
    int last_srv;
    int age;

    typedef struct packed {
        logic [11:0]  adr;
        logic [127:0] dat;
        logic [15:0]  sel;
        logic         stb;
        logic         cyc;
        logic         we;
        logic         ack0;
        logic         ack1;
        logic         rty0;
        logic         rty1;
    } obs_t;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_adr   (m_adr[0]),
        .m0_dat_m (m_dat[0]),
        .m0_sel   (m_sel[0]),
        .m0_stb   (m_stb[0]),
        .m0_cyc   (m_cyc[0]),
        .m0_we    (m_we[0]),
        .m0_ack   (m0_ack),
        .m0_rty   (m0_rty),
        .m0_dat_s (m0_dat_s),
        .m1_adr   (m_adr[1]),
        .m1_dat_m (m_dat[1]),
        .m1_sel   (m_sel[1]),
        .m1_stb   (m_stb[1]),
        .m1_cyc   (m_cyc[1]),
        .m1_we    (m_we[1]),
        .m1_ack   (m1_ack),
        .m1_rty   (m1_rty),
        .m1_dat_s (m1_dat_s),
        .s_adr    (s_adr),
        .s_dat_m  (s_dat_m),
        .s_sel    (s_sel),
        .s_stb    (s_stb),
        .s_cyc    (s_cyc),
        .s_we     (s_we),
        .s_ack    (s_ack),
        .s_rty    (s_rty),
        .s_dat_s  (s_dat_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t actual();
        return '{adr: s_adr, dat: s_dat_m, sel: s_sel, stb: s_stb, cyc: s_cyc,
                 we: s_we, ack0: m0_ack, ack1: m1_ack, rty0: m0_rty, rty1: m1_rty};
    endfunction

    function automatic bit timed_out();
        return TO_EN && (own >= 0) && (age == TO) && !s_ack;
    endfunction

    // Expected outputs from the arbitration rules given current model state.
    function automatic obs_t model_out();
        obs_t e;
        bit   t;
        e = '0;
        t = timed_out();
        if (own >= 0) begin
            e.adr = m_adr[own];
            e.dat = m_dat[own];
            e.sel = m_sel[own];
            e.stb = m_stb[own] && !t;
            e.cyc = m_cyc[own];
            e.we  = m_we[own];
            if (own == 0) begin
                e.ack0 = s_ack;
                e.rty0 = s_rty || t;
            end else begin
                e.ack1 = s_ack;
                e.rty1 = s_rty || t;
            end
        end
        return e;
    endfunction

    task automatic model_step();
        bit t;
        t = timed_out();
        if (own < 0) begin
            age = 1;
            if (m_stb[0] && m_stb[1]) own = (last_srv == 1) ? 0 : 1;
            else if (m_stb[0])        own = 0;
            else if (m_stb[1])        own = 1;
        end else if (s_ack || s_rty || t) begin
            last_srv = own;
            own      = -1;
        end else if (!m_stb[own]) begin
            own = -1;
        end else begin
            age++;
        end
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0;
            m_stb[i] = 1'b0; m_cyc[i] = 1'b0; m_we[i] = 1'b0;
        end
        s_ack = 1'b0; s_rty = 1'b0; s_dat_s = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        own = -1; last_srv = 1; age = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        m_stb[0] = 1'b1; m_cyc[0] = 1'b1; m_adr[0] = 12'h5A5;
        m_stb[1] = 1'b1; m_cyc[1] = 1'b1; m_adr[1] = 12'hA5A;
        s_ack = 1'b1; s_rty = 1'b1;
        s_dat_s = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (actual() !== obs_t'('0)) begin
                n_err++;
                $display("FAIL reset_outputs: got %h required 0", actual());
            end
            n_cmp++;
            if (m0_dat_s !== s_dat_s || m1_dat_s !== s_dat_s) begin
                n_err++;
                $display("FAIL reset_dat_s: got %h/%h required %h", m0_dat_s, m1_dat_s, s_dat_s);
            end
        end
        do_reset();
    endtask

    task automatic test_m0_read();
        do_reset();
        m_adr[0] = 12'h123; m_stb[0] = 1'b1; m_cyc[0] = 1'b1; m_we[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_stb !== 1'b0) begin
            n_err++;
            $display("FAIL read_arb_cycle: s_stb got %b required 0", s_stb);
        end
        adv();
        for (int k = 1; k <= 3; k++) begin
            s_ack = (k == 3);
            @(negedge clk);
            n_cmp++;
            if (s_adr !== 12'h123 || s_stb !== 1'b1 || s_we !== 1'b0) begin
                n_err++;
                $display("FAIL read_req k=%0d: adr %h stb %b we %b required 123 1 0", k, s_adr, s_stb, s_we);
            end
            n_cmp++;
            if (m0_ack !== (k == 3) || m1_ack !== 1'b0) begin
                n_err++;
                $display("FAIL read_ack k=%0d: m0_ack %b m1_ack %b required %b 0", k, m0_ack, m1_ack, k == 3);
            end
            adv();
        end
        m_stb[0] = 1'b0; m_cyc[0] = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (m0_ack !== 1'b0 || s_stb !== 1'b0) begin
            n_err++;
            $display("FAIL read_after: m0_ack %b s_stb %b required 0 0", m0_ack, s_stb);
        end
        adv();
    endtask

    task automatic test_round_robin();
        int got [$];
        int want [4] = '{0, 1, 0, 1};
        do_reset();
        m_adr[0] = 12'hAAA; m_adr[1] = 12'hBBB;
        m_stb[0] = 1'b1; m_cyc[0] = 1'b1; m_stb[1] = 1'b1; m_cyc[1] = 1'b1;
        s_ack = 1'b1;
        for (int k = 0; k < 20 && got.size() < 4; k++) begin
            @(negedge clk);
            if (s_stb) begin
                got.push_back((s_adr == 12'hBBB) ? 1 : 0);
                n_cmp++;
                if (m0_ack !== (s_adr == 12'hAAA) || m1_ack !== (s_adr == 12'hBBB)) begin
                    n_err++;
                    $display("FAIL rr_ack_route: adr %h m0_ack %b m1_ack %b", s_adr, m0_ack, m1_ack);
                end
            end
            adv();
        end
        n_cmp++;
        if (got.size() != 4) begin
            n_err++;
            $display("FAIL rr_count: got %0d grants required 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got[i] != want[i]) begin
                    n_err++;
                    $display("FAIL rr_order[%0d]: got m%0d required m%0d", i, got[i], want[i]);
                end
            end
        end
        clear_inputs();
        adv();
    endtask

    task automatic test_m1_write();
        logic [127:0] d;
        d = {4{32'hA5A5A5A5}};
        do_reset();
        m_adr[1] = 12'h3C7; m_dat[1] = d; m_sel[1] = 16'h00F0;
        m_we[1] = 1'b1; m_stb[1] = 1'b1; m_cyc[1] = 1'b1;
        adv();
        // m0 arriving mid-grant must not disturb the m1 transfer.
        m_adr[0] = 12'h111; m_stb[0] = 1'b1; m_cyc[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            s_ack = (k == 4);
            @(negedge clk);
            n_cmp++;
            if (s_we !== 1'b1 || s_sel !== 16'h00F0 || s_dat_m !== d || s_adr !== 12'h3C7 || s_stb !== 1'b1) begin
                n_err++;
                $display("FAIL write_req k=%0d: we %b sel %h adr %h dat %h", k, s_we, s_sel, s_adr, s_dat_m);
            end
            n_cmp++;
            if (m1_ack !== (k == 4) || m0_ack !== 1'b0) begin
                n_err++;
                $display("FAIL write_ack k=%0d: m1_ack %b m0_ack %b required %b 0", k, m1_ack, m0_ack, k == 4);
            end
            adv();
        end
        clear_inputs();
        adv();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_adr[0] = 12'h0F0; m_stb[0] = 1'b1; m_cyc[0] = 1'b1;
        m_adr[1] = 12'h0E0;
        adv();
        @(negedge clk);
        n_cmp++;
        if (s_stb !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: s_stb got %b required 1", s_stb);
        end
        rst_n = 1'b0; s_ack = 1'b1;
        own = -1; last_srv = 1; age = 0;
        #1;
        n_cmp++;
        if (s_stb !== 1'b0 || m0_ack !== 1'b0 || s_adr !== 12'h000) begin
            n_err++;
            $display("FAIL rstmid_drop: s_stb %b m0_ack %b adr %h required 0 0 000", s_stb, m0_ack, s_adr);
        end
        @(negedge clk);
        rst_n = 1'b1; s_ack = 1'b0; m_stb[1] = 1'b1; m_cyc[1] = 1'b1;
        #1;
        n_cmp++;
        if (s_stb !== 1'b0 || m0_ack !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_idle: s_stb %b m0_ack %b required 0 0", s_stb, m0_ack);
        end
        adv();
        @(negedge clk);
        n_cmp++;
        if (s_adr !== 12'h0F0 || s_stb !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_tie: adr %h stb %b required 0f0 1", s_adr, s_stb);
        end
        clear_inputs();
        adv();
        adv();
    endtask

    task automatic test_abort();
        do_reset();
        m_adr[0] = 12'h200; m_adr[1] = 12'h300;
        m_stb[0] = 1'b1; m_cyc[0] = 1'b1;
        adv();
        m_stb[0] = 1'b0; m_cyc[0] = 1'b0; m_stb[1] = 1'b1; m_cyc[1] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (s_stb !== 1'b0 || s_adr !== 12'h200) begin
            n_err++;
            $display("FAIL abort_cycle: stb %b adr %h required 0 200", s_stb, s_adr);
        end
        adv();
        m_stb[0] = 1'b1; m_cyc[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (s_stb !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: s_stb got %b required 0", s_stb);
        end
        adv();
        s_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (s_adr !== 12'h200 || m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            n_err++;
            $display("FAIL abort_regrant: adr %h m0_ack %b m1_ack %b required 200 1 0", s_adr, m0_ack, m1_ack);
        end
        clear_inputs();
        adv();
    endtask

    task automatic test_grant_limit();
        int rty_at;
        bool_hold_t:
        begin
            rty_at = 0;
            do_reset();
            m_adr[0] = 12'h400; m_adr[1] = 12'h500;
            m_stb[0] = 1'b1; m_cyc[0] = 1'b1;
            adv();
            m_stb[1] = 1'b1; m_cyc[1] = 1'b1;
            for (int k = 1; k <= 20 && rty_at == 0; k++) begin
                @(negedge clk);
                if (m0_rty) begin
                    rty_at = k;
                    n_cmp++;
                    if (s_stb !== 1'b0) begin
                        n_err++;
                        $display("FAIL timeout_stb: s_stb got %b required 0", s_stb);
                    end
                end
                adv();
            end
            n_cmp++;
            if (rty_at != (TO_EN ? TO : 0)) begin
                n_err++;
                $display("FAIL grant_limit: m0_rty at cycle %0d required %0d", rty_at, TO_EN ? TO : 0);
            end
            @(negedge clk);
            adv();
            @(negedge clk);
            n_cmp++;
            if (s_stb !== 1'b1 || s_adr !== (TO_EN ? 12'h500 : 12'h400)) begin
                n_err++;
                $display("FAIL grant_after: stb %b adr %h required 1 %h", s_stb, s_adr, TO_EN ? 12'h500 : 12'h400);
            end
            clear_inputs();
            s_ack = 1'b1;
            adv();
            s_ack = 1'b0;
            adv();
        end
    endtask

    task automatic test_random();
        obs_t e;
        obs_t a;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                m_stb[i] = ($urandom_range(0, 9) < 7);
                m_cyc[i] = m_stb[i];
                m_we[i]  = $urandom_range(0, 1) == 1;
                m_adr[i] = 12'($urandom);
                m_sel[i] = 16'($urandom);
                m_dat[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            s_ack   = ($urandom_range(0, 4) == 0);
            s_rty   = ($urandom_range(0, 15) == 0);
            s_dat_s = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            e = model_out();
            a = actual();
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL random k=%0d: got %h required %h", k, a, e);
            end
            n_cmp++;
            if (m0_dat_s !== s_dat_s || m1_dat_s !== s_dat_s) begin
                n_err++;
                $display("FAIL random_dat_s k=%0d: got %h/%h required %h", k, m0_dat_s, m1_dat_s, s_dat_s);
            end
            adv();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        own = -1; last_srv = 1; age = 0;
        test_reset();
        test_m0_read();
        test_round_robin();
        test_m1_write();
        test_reset_mid();
        test_abort();
        test_grant_limit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
